uart_rxcore: RTL and testbench

UART_RXCORE -- requirements
Module: uart_rxcore

---
 rtl/uart_rxcore.sv | 161 ++++++++++++++++
 tb/tb_uart_rxcore.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rxcore.sv
// uart_rxcore: oversampled UART receiver (7/8 data bits, optional parity, 1/2 stop bits).
// Ports: CLK, RST (async high), iSEVEN_BIT, iPARITY_EN, iODD_PARITY, iSTOP_BIT, iUART_RX
//        -> oRETRY, oPARITY_ERROR, oDE, oDATA[7:0].
// Build option: define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling.
module uart_rxcore #(
  parameter int OVER_SAMPLING = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       iSEVEN_BIT,
  input  logic       iPARITY_EN,
  input  logic       iODD_PARITY,
  input  logic       iSTOP_BIT,
  input  logic       iUART_RX,
  output logic       oRETRY,
  output logic       oPARITY_ERROR,
  output logic       oDE,
  output logic [7:0] oDATA
);

  localparam int CW = $clog2(OVER_SAMPLING + 1);
  localparam logic [CW-1:0] HALF = CW'(OVER_SAMPLING / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVER_SAMPLING);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic          par;
  logic          stop2nd;
  logic          armed;
  logic          seven, pen, odd, two;
  logic          s1, rxs;
  logic          bitv;
  logic          tick;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1  <= 1'b1;
      rxs <= 1'b1;
    end else begin
      s1  <= iUART_RX;
      rxs <= s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // s1 is next cycle's rxs, so the vote window is centred on the
  // sample cycle without moving the decision point.
  logic rxp;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) rxp <= 1'b1;
    else     rxp <= rxs;
  end

  assign bitv = (rxp & rxs) | (rxp & s1) | (rxs & s1);
`else
  assign bitv = rxs;
`endif

  // cnt equals cycles elapsed since the last sample (or start detect)
  always_comb begin
    tick = 1'b0;
    if (state == START) tick = (cnt == HALF);
    else                tick = (cnt == FULL);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state         <= IDLE;
      cnt           <= '0;
      bcnt          <= '0;
      sh            <= '0;
      par           <= 1'b0;
      stop2nd       <= 1'b0;
      armed         <= 1'b1;
      seven         <= 1'b0;
      pen           <= 1'b0;
      odd           <= 1'b0;
      two           <= 1'b0;
      oRETRY        <= 1'b0;
      oPARITY_ERROR <= 1'b0;
      oDE           <= 1'b0;
      oDATA         <= 8'h00;
    end else begin
      oRETRY        <= 1'b0;
      oPARITY_ERROR <= 1'b0;
      oDE           <= 1'b0;
      if (state != IDLE) begin
        if (tick) cnt <= CW'(1);
        else      cnt <= cnt + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (!armed) begin
            armed <= rxs;
          end else if (!rxs) begin
            state   <= START;
            cnt     <= CW'(1);
            bcnt    <= '0;
            par     <= 1'b0;
            stop2nd <= 1'b0;
            seven   <= iSEVEN_BIT;
            pen     <= iPARITY_EN;
            odd     <= iODD_PARITY;
            two     <= iSTOP_BIT;
          end
        end
        START: begin
          if (tick) begin
            if (bitv) begin
              oRETRY <= 1'b1;
              state  <= IDLE;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (tick) begin
            sh   <= {bitv, sh[7:1]};
            par  <= par ^ bitv;
            bcnt <= bcnt + 1'b1;
            if (bcnt == (seven ? 3'd6 : 3'd7))
              state <= pen ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (tick) begin
            par   <= par ^ bitv;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (!bitv) begin
              oRETRY <= 1'b1;
              armed  <= 1'b0;
              state  <= IDLE;
            end else if (two && !stop2nd) begin
              stop2nd <= 1'b1;
            end else begin
              // 7-bit frames leave data in sh[7:1]
              oDATA         <= seven ? {1'b0, sh[7:1]} : sh;
              oDE           <= 1'b1;
              oPARITY_ERROR <= pen & (par ^ odd);
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rxcore.sv
// tb_uart_rxcore: directed scoreboard bench for uart_rxcore.
// Drives serial frames, queues expected bytes, checks oDE/oDATA/oPARITY_ERROR/oRETRY.
module tb_uart_rxcore;

  localparam int OS = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       iSEVEN_BIT = 1'b0;
  logic       iPARITY_EN = 1'b0;
  logic       iODD_PARITY = 1'b0;
  logic       iSTOP_BIT = 1'b0;
  logic       iUART_RX = 1'b1;
  logic       oRETRY;
  logic       oPARITY_ERROR;
  logic       oDE;
  logic [7:0] oDATA;

  uart_rxcore #(.OVER_SAMPLING(OS)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .iSEVEN_BIT   (iSEVEN_BIT),
    .iPARITY_EN   (iPARITY_EN),
    .iODD_PARITY  (iODD_PARITY),
    .iSTOP_BIT    (iSTOP_BIT),
    .iUART_RX     (iUART_RX),
    .oRETRY       (oRETRY),
    .oPARITY_ERROR(oPARITY_ERROR),
    .oDE          (oDE),
    .oDATA        (oDATA)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
  } exp_t;

  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_de = 0;
  int n_retry = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (!RST) begin
      if (oRETRY) n_retry++;
      if (oDE || oRETRY)
        chk("de_retry_excl", 32'(oDE & oRETRY), 32'd0);
      if (oPARITY_ERROR)
        chk("perr_needs_de", 32'(oDE), 32'd1);
      if (oDE) begin
        n_de++;
        chk("de_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          chk("data", 32'(oDATA), 32'(e.d));
          chk("perr", 32'(oPARITY_ERROR), 32'(e.pe));
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    iUART_RX = b;
    repeat (OS) @(negedge CLK);
  endtask

  // scramble flips the config inputs right after the start bit
  task automatic send_frame(input logic [7:0] d, input logic seven,
                            input logic pen, input logic odd_p,
                            input logic two, input logic bad_par,
                            input logic bad_stop2, input logic scramble);
    logic [7:0] dd;
    logic pb;
    dd = seven ? {1'b0, d[6:0]} : d;
    pb = (^dd) ^ odd_p;
    if (!bad_stop2) q.push_back({dd, pen & bad_par});
    iSEVEN_BIT  = seven;
    iPARITY_EN  = pen;
    iODD_PARITY = odd_p;
    iSTOP_BIT   = two;
    send_bit(1'b0);
    if (scramble) begin
      iSEVEN_BIT  = ~seven;
      iPARITY_EN  = ~pen;
      iODD_PARITY = ~odd_p;
      iSTOP_BIT   = ~two;
    end
    for (int i = 0; i < (seven ? 7 : 8); i++) send_bit(dd[i]);
    if (pen) send_bit(pb ^ bad_par);
    send_bit(1'b1);
    if (two) send_bit(~bad_stop2);
    iUART_RX = 1'b1;
  endtask

  task automatic settle();
    repeat (3 * OS) @(negedge CLK);
    chk("queue_drained", 32'(q.size()), 32'd0);
  endtask

  initial begin
    int r0;
    int d0;
    logic [7:0] dmid;

    // reset state
    repeat (3) @(negedge CLK);
    chk("rst_data", 32'(oDATA), 32'h00);
    chk("rst_de", 32'(oDE), 32'd0);
    chk("rst_retry", 32'(oRETRY), 32'd0);
    chk("rst_perr", 32'(oPARITY_ERROR), 32'd0);
    RST = 1'b0;
    repeat (2 * OS) @(negedge CLK);

    // 8N1 0x55
    r0 = n_retry;
    send_frame(8'h55, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("8n1_de_cnt", 32'(n_de), 32'd1);
    chk("8n1_retry", 32'(n_retry - r0), 32'd0);
    chk("8n1_hold", 32'(oDATA), 32'h55);

    // 7N1 "stop\n" back-to-back
    send_frame(8'h73, 1, 0, 0, 0, 0, 0, 0);
    send_frame(8'h74, 1, 0, 0, 0, 0, 0, 0);
    send_frame(8'h6F, 1, 0, 0, 0, 0, 0, 0);
    send_frame(8'h70, 1, 0, 0, 0, 0, 0, 0);
    send_frame(8'h0A, 1, 0, 0, 0, 0, 0, 0);
    settle();
    chk("7n1_de_cnt", 32'(n_de), 32'd6);
    chk("7n1_last", 32'(oDATA), 32'h0A);
    chk("7n1_retry", 32'(n_retry - r0), 32'd0);

    // 8E1 bad then good parity, then 8O1
    send_frame(8'hA3, 0, 1, 0, 0, 1, 0, 0);
    settle();
    send_frame(8'hA3, 0, 1, 0, 0, 0, 0, 0);
    settle();
    send_frame(8'h5A, 0, 1, 1, 0, 0, 0, 0);
    settle();
    chk("par_de_cnt", 32'(n_de), 32'd9);

    // 2-cycle glitch
    r0 = n_retry;
    d0 = n_de;
    iUART_RX = 1'b0;
    repeat (2) @(negedge CLK);
    iUART_RX = 1'b1;
    repeat (2 * OS) @(negedge CLK);
    chk("glitch_retry", 32'(n_retry - r0), 32'd1);
    chk("glitch_no_de", 32'(n_de - d0), 32'd0);

    // 8N2 with bad second stop, then 0x3C
    r0 = n_retry;
    send_frame(8'h81, 0, 0, 0, 1, 0, 1, 0);
    repeat (2 * OS) @(negedge CLK);
    chk("frm_retry", 32'(n_retry - r0), 32'd1);
    chk("frm_no_de", 32'(n_de - d0), 32'd0);
    chk("frm_hold", 32'(oDATA), 32'h5A);
    send_frame(8'h3C, 0, 0, 0, 1, 0, 0, 0);
    settle();
    chk("frm_next", 32'(oDATA), 32'h3C);

    // config change mid-frame is ignored
    send_frame(8'h96, 0, 0, 0, 0, 0, 0, 1);
    settle();
    chk("latch_cfg", 32'(oDATA), 32'h96);

    // reset during data bit 4
    r0 = n_retry;
    d0 = n_de;
    dmid = 8'h0F;
    iSEVEN_BIT = 1'b0;
    iPARITY_EN = 1'b0;
    iSTOP_BIT  = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(dmid[i]);
    iUART_RX = dmid[4];
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_data", 32'(oDATA), 32'h00);
    chk("arst_de", 32'(oDE), 32'd0);
    chk("arst_retry", 32'(oRETRY), 32'd0);
    @(negedge CLK);
    repeat (OS - 4) @(negedge CLK);
    for (int i = 5; i < 8; i++) send_bit(dmid[i]);
    send_bit(1'b1);
    RST = 1'b0;
    repeat (2 * OS) @(negedge CLK);
    chk("arst_no_pulse", 32'(n_de - d0), 32'd0);
    send_frame(8'hF0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("arst_next", 32'(oDATA), 32'hF0);
    chk("arst_retry_cnt", 32'(n_retry - r0), 32'd0);
    chk("total_de", 32'(n_de), 32'd12);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
